// File: rtl/core_run_ctrl_if.sv
// Program-load port and instruction-memory write port of the run/load sequencer.
interface core_run_ctrl_if #(
    parameter int ADDR_W = 6
);
    logic              load_valid;
    logic [31:0]       load_data;
    logic              load_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;

    modport master (
        output load_valid, load_data,
        input  load_ready, imem_we, imem_waddr, imem_wdata
    );

    modport slave (
        input  load_valid, load_data,
        output load_ready, imem_we, imem_waddr, imem_wdata
    );
endinterface

// File: rtl/core_run_ctrl.sv
// Run/load sequencer: streams a program into IMEM, clears the PC, gates commit, counts retires.
// Define RUN_CTRL_STEP_EN to build the debug PAUSE state with dbg_pause/dbg_step.
module core_run_ctrl #(
    parameter int IMEM_DEPTH = 64,
    parameter int ADDR_W     = 6,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             core_load,
    input  logic             dbg_pause,
    input  logic             dbg_step,
    core_run_ctrl_if.slave   ld,
    output logic             pc_clr,
    output logic             core_en,
    output logic             busy,
    output logic             halted,
    output logic             load_err,
    output logic [CNT_W-1:0] instret
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_HALT  = 3'd3
`ifdef RUN_CTRL_STEP_EN
        , S_PAUSE = 3'd4
`endif
    } state_t;

    localparam logic [ADDR_W:0] FULL_PTR = (ADDR_W+1)'(IMEM_DEPTH);

    state_t           state_r;
    state_t           state_s;
    logic [ADDR_W:0]  wptr_r;
    logic [CNT_W-1:0] instret_r;
    logic             load_err_r;
    logic             pc_clr_r;
    logic             busy_r;
    logic             halted_r;
    logic             full_s;
    logic             pause_s;
    logic             ready_s;
    logic             we_s;
    logic             err_set_s;
    logic             core_en_s;
    logic             busy_s;

    assign full_s = (wptr_r == FULL_PTR);

`ifdef RUN_CTRL_STEP_EN
    assign pause_s = dbg_pause;
    assign busy_s  = (state_s == S_CLEAR) | (state_s == S_RUN) | (state_s == S_PAUSE);
`else
    logic unused_dbg_s;
    assign unused_dbg_s = dbg_pause | dbg_step;
    assign pause_s      = 1'b0;
    assign busy_s       = (state_s == S_CLEAR) | (state_s == S_RUN);
`endif

    // Next-state, load handshake and commit-enable decode; abort overrides everything.
    always_comb begin
        state_s   = state_r;
        ready_s   = 1'b0;
        we_s      = 1'b0;
        err_set_s = 1'b0;
        core_en_s = 1'b0;
        if (abort) begin
            state_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    ready_s   = !full_s & !start;
                    we_s      = ready_s & ld.load_valid & !rst;
                    err_set_s = ld.load_valid & full_s;
                    if (start) begin
                        state_s = S_CLEAR;
                    end else begin
                        state_s = S_IDLE;
                    end
                end
                S_CLEAR: begin
                    state_s = S_RUN;
                end
                S_RUN: begin
                    core_en_s = core_load & !pause_s;
                    if (!core_load) begin
                        state_s = S_HALT;
`ifdef RUN_CTRL_STEP_EN
                    end else if (pause_s) begin
                        state_s = S_PAUSE;
`endif
                    end else begin
                        state_s = S_RUN;
                    end
                end
                S_HALT: begin
                    if (start) begin
                        state_s = S_CLEAR;
                    end else begin
                        state_s = S_HALT;
                    end
                end
`ifdef RUN_CTRL_STEP_EN
                S_PAUSE: begin
                    // A step coinciding with pause release still executes before RUN resumes.
                    core_en_s = dbg_step & core_load;
                    if (dbg_step & !core_load) begin
                        state_s = S_HALT;
                    end else if (!dbg_pause) begin
                        state_s = S_RUN;
                    end else begin
                        state_s = S_PAUSE;
                    end
                end
`endif
                default: begin
                    state_s = S_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Write pointer: advances per accepted beat, rewinds on abort so a new program can load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_r <= {(ADDR_W+1){1'b0}};
        end else if (abort) begin
            wptr_r <= {(ADDR_W+1){1'b0}};
        end else if (we_s) begin
            wptr_r <= wptr_r + {{ADDR_W{1'b0}}, 1'b1};
        end
    end

    // Retired-instruction counter, zeroed in CLEAR and saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_r <= {CNT_W{1'b0}};
        end else if (state_r == S_CLEAR) begin
            instret_r <= {CNT_W{1'b0}};
        end else if (core_en_s && (instret_r != {CNT_W{1'b1}})) begin
            instret_r <= instret_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Sticky overflow flag and state-decoded status outputs registered from next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_err_r <= 1'b0;
            pc_clr_r   <= 1'b0;
            busy_r     <= 1'b0;
            halted_r   <= 1'b0;
        end else begin
            load_err_r <= load_err_r | err_set_s;
            pc_clr_r   <= (state_s == S_CLEAR);
            busy_r     <= busy_s;
            halted_r   <= (state_s == S_HALT);
        end
    end

    assign ld.load_ready = ready_s;
    assign ld.imem_we    = we_s;
    assign ld.imem_waddr = wptr_r[ADDR_W-1:0];
    assign ld.imem_wdata = ld.load_data;
    assign core_en       = core_en_s;
    assign pc_clr        = pc_clr_r;
    assign busy          = busy_r;
    assign halted        = halted_r;
    assign load_err      = load_err_r;
    assign instret       = instret_r;
endmodule
